stack_controller: RTL

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stack_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/stack_controller.sv
// LIFO stack controller: registered pop data with a one-cycle rvalid pulse and sticky ovf/unf flags.
// Define STACK_OCCUPANCY_EN to add the count and almost_full outputs.
module stack_controller #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
`ifdef STACK_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [SW-1:0]    sp_reg;
    logic [SW-1:0]    sp_next;
    logic [WIDTH-1:0] rdata_reg;
    logic             rvalid_reg;
    logic             ovf_reg;
    logic             unf_reg;

    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_set;
    logic             unf_set;

    // When sp==DEPTH the low bits wrap to 0, so subtracting 1 still lands on DEPTH-1.
    assign top_idx = sp_reg[AW-1:0] - AW'(1);

    assign empty = (sp_reg == '0);
    assign full  = (sp_reg == SW'(DEPTH));

    always_comb begin
        sp_next = sp_reg;
        wr_en   = 1'b0;
        wr_addr = sp_reg[AW-1:0];
        rd_en   = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (flush) begin
            sp_next = '0;
        end else if (push && pop) begin
            if (empty) begin
                wr_en   = 1'b1;
                sp_next = sp_reg + SW'(1);
                unf_set = 1'b1;
            end else begin
                // Replace: old top is read out while the new word overwrites it.
                wr_en   = 1'b1;
                wr_addr = top_idx;
                rd_en   = 1'b1;
            end
        end else if (push) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en   = 1'b1;
                sp_next = sp_reg + SW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                rd_en   = 1'b1;
                sp_next = sp_reg - SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg     <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            sp_reg     <= sp_next;
            rvalid_reg <= rd_en;
            if (rd_en) begin
                rdata_reg <= mem[top_idx];
            end
            // A new error event beats a simultaneous clear.
            ovf_reg <= ovf_set | (ovf_reg & ~err_clr);
            unf_reg <= unf_set | (unf_reg & ~err_clr);
        end
    end

    // Storage carries no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wdata;
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;

`ifdef STACK_OCCUPANCY_EN
    assign count       = sp_reg;
    assign almost_full = (sp_reg >= SW'(DEPTH - 1));
`endif

endmodule
